// File: rtl/inverter_pkg.sv
// inverter_pkg: mode encoding shared by the inverter pipeline
package inverter_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_MASK   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;
endpackage

// File: rtl/inv_stage.sv
// inv_stage: one elastic register slice with valid/ready hand-off
module inv_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);
  logic load;
  assign load = !dn_valid || dn_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (load) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end
endmodule

// File: rtl/inverter_pipe.sv
// inverter_pipe: elastic pipelined inverter bank with per-word transform mode
module inverter_pipe
  import inverter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [WIDTH-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);
  mode_e            mode;
  logic             tog;
  logic             r;
  logic [WIDTH-1:0] xf;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] dn_rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [WIDTH-1:0] d    [DEPTH];
  assign mode = mode_e'(in_mode);
  always_comb begin
    xf = mode == MODE_PASS ? in_data :
         mode == MODE_INV  ? ~in_data :
         mode == MODE_MASK ? in_data ^ in_mask :
                             in_data ^ {WIDTH{tog}};
  end
  // a stage can take a word if it or any stage ahead of it is empty, or the sink drains
  always_comb begin
    r = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      dn_rdy[i] = r;
      r = r | ~v[i];
    end
    in_ready = r;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) tog <= 1'b0;
    else if (in_valid && in_ready && mode == MODE_TOGGLE) tog <= ~tog;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v[i] = in_valid;
      assign up_d[i] = xf;
    end else begin : g_body
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end
    inv_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_valid(up_v[i]),
      .up_data (up_d[i]),
      .dn_ready(dn_rdy[i]),
      .dn_valid(v[i]),
      .dn_data (d[i])
    );
  end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule
